mem2axi_egress: RTL and testbench

- Downstream of the memory arbiter: consumes 202-bit memory words read from one output queue's first-word-fall-through read FIFO.
- Reassembles them into 256-bit AXI4-Stream beats for the output MAC port.
- Each packet is stored as one header word (carries tuser) followed by pairs of half-beat words (low half, then high half).
- Flags framing errors and counts delivered packets.

---
 rtl/mem2axi_egress.sv | 87 ++++++++
 tb/tb_mem2axi_egress.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem2axi_egress.sv
// mem2axi_egress: reassembles header + half-beat memory words into AXI4-Stream beats,
// flags framing errors and counts delivered packets.
module mem2axi_egress #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128,
  parameter int MEM_W  = 202,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [MEM_W-1:0]    din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tstrb,
  output logic [USER_W-1:0]   m_axis_tuser,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  output logic [CNT_W-1:0]    pkt_count,
  output logic                framing_err
);
  localparam int HALF_W  = DATA_W/2;
  localparam int HSTRB_W = DATA_W/16;
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
  state_t state, state_nx;
  logic free, pop, load, short_pkt, hdr_load, stage, err_set;
  logic eop, sop, half;
  logic [HALF_W-1:0] d, stg_data;
  logic [HSTRB_W-1:0] s, stg_strb;
  logic unused;
  assign eop    = din[MEM_W-1];
  assign sop    = din[MEM_W-2];
  assign half   = din[MEM_W-3];
  assign d      = din[HALF_W-1:0];
  assign s      = din[HALF_W+HSTRB_W-1:HALF_W];
  assign unused = ^din[MEM_W-4:HALF_W+HSTRB_W];
  assign free   = ~m_axis_tvalid | m_axis_tready;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    if (pop)
      case (state)
        IDLE:    state_nx = sop ? LOW : IDLE;
        LOW:     state_nx = eop ? IDLE : HIGH;
        default: state_nx = eop ? IDLE : LOW;
      endcase
  end
  // A non-final low half only goes to staging, so it may be popped while the output is blocked.
  always_comb begin
    din_ready = ~reset & (((state == LOW) & ~eop) | free);
    pop       = din_valid & din_ready;
    short_pkt = (state == LOW) & eop;
    hdr_load  = pop & (state == IDLE) & sop;
    stage     = pop & (state == LOW) & ~eop;
    load      = pop & ((state == HIGH) | short_pkt);
    err_set   = pop & ((state == IDLE) ? ~sop : (sop | (half != (state == HIGH)) | short_pkt));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      stg_data      <= '0;
      stg_strb      <= '0;
      pkt_count     <= '0;
      framing_err   <= 1'b0;
    end else begin
      if (hdr_load) m_axis_tuser <= din[USER_W-1:0];
      if (stage) begin
        stg_data <= d;
        stg_strb <= s;
      end
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= short_pkt ? {{HALF_W{1'b0}}, d} : {d, stg_data};
        m_axis_tstrb  <= short_pkt ? {{HSTRB_W{1'b0}}, s} : {s, stg_strb};
        m_axis_tlast  <= eop;
      end else if (m_axis_tready) m_axis_tvalid <= 1'b0;
      if (m_axis_tvalid & m_axis_tready & m_axis_tlast) pkt_count <= pkt_count + CNT_W'(1);
      if (err_set) framing_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem2axi_egress.sv
// tb_mem2axi_egress: randomized FIFO/tready stimulus checked against a packet-level reference model.
module tb_mem2axi_egress;
  logic clk = 1'b0, reset = 1'b1;
  logic [201:0] din = '0;
  logic din_valid = 1'b0, din_ready;
  logic [255:0] m_axis_tdata;
  logic [31:0] m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b0;
  logic [31:0] pkt_count;
  logic framing_err;
  always #5 clk = ~clk;
  mem2axi_egress dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .pkt_count(pkt_count), .framing_err(framing_err)
  );
  typedef struct {logic [255:0] d; logic [31:0] s; logic [127:0] u; logic l;} beat_t;
  logic [201:0] fifo[$];
  beat_t exp_q[$];
  beat_t held, last;
  int total = 0, bad = 0;
  int m_mode = 0, m_cnt = 0;
  logic m_err = 1'b0;
  logic [127:0] m_tu = '0, m_lo = '0;
  logic [15:0] m_los = '0;
  int trdy_mode = 0;
  bit gaps = 0, tog = 0, hold = 0;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Word-level packet parser: header, then low/high pairs; produces the expected beat list.
  task automatic push(input logic [201:0] w);
    logic eop, sop, half;
    eop = w[201]; sop = w[200]; half = w[199];
    fifo.push_back(w);
    if (m_mode == 0) begin
      if (sop) begin m_tu = w[127:0]; m_mode = 1; end
      else m_err = 1'b1;
    end else begin
      if (sop || half != (m_mode == 2)) m_err = 1'b1;
      if (m_mode == 1 && eop) begin
        exp_q.push_back('{{128'd0, w[127:0]}, {16'd0, w[143:128]}, m_tu, 1'b1});
        m_err = 1'b1; m_cnt++; m_mode = 0;
      end else if (m_mode == 1) begin
        m_lo = w[127:0]; m_los = w[143:128]; m_mode = 2;
      end else begin
        exp_q.push_back('{{w[127:0], m_lo}, {w[143:128], m_los}, m_tu, eop});
        if (eop) m_cnt++;
        m_mode = eop ? 0 : 1;
      end
    end
  endtask
  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic gen_pkt(input logic [127:0] tu, input int nb, input bit short_end, input int bad_kind);
    logic [201:0] w;
    if (bad_kind == 3) push({3'b000, 55'd0, 16'hFFFF, r128()});
    push({3'b010, 55'd0, 16'd0, tu});
    for (int i = 0; i < nb; i++)
      for (int h = 0; h < 2; h++) begin
        w = {(i == nb-1 && h == 1 && !short_end), 1'b0, h[0], 55'({$urandom, $urandom}), 16'($urandom), r128()};
        if (bad_kind == 1 && i == 0 && h == 1) w[199] = 1'b0;
        if (bad_kind == 2 && i == 0 && h == 0) w[200] = 1'b1;
        push(w);
      end
    if (short_end) push({3'b100, 55'd0, 16'($urandom), r128()});
  endtask
  task automatic step();
    beat_t e, cur;
    @(negedge clk);
    din_valid = fifo.size() > 0 && (!gaps || $urandom_range(0, 3) != 0);
    din = fifo.size() > 0 ? fifo[0] : '0;
    tog = ~tog;
    m_axis_tready = trdy_mode == 0 ? 1'b1 : trdy_mode == 1 ? tog : 1'($urandom_range(0, 1));
    #1;
    cur = '{m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast};
    if (hold) begin
      chk("hold_valid", m_axis_tvalid, 1);
      chk("hold_data", cur.d, held.d);
      chk("hold_strb", cur.s, held.s);
      chk("hold_user", cur.u, held.u);
      chk("hold_last", cur.l, held.l);
    end
    if (din_valid && din_ready) void'(fifo.pop_front());
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) chk("extra_beat", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("tdata", cur.d, e.d);
        chk("tstrb", cur.s, e.s);
        chk("tuser", cur.u, e.u);
        chk("tlast", cur.l, e.l);
      end
      last = cur;
    end
    hold = m_axis_tvalid && !m_axis_tready;
    held = cur;
  endtask
  task automatic drain();
    int n = 0;
    while ((fifo.size() > 0 || exp_q.size() > 0 || m_axis_tvalid) && n < 3000) begin
      step();
      n++;
    end
    step();
    chk("drain_timeout", n < 3000, 1);
    chk("pkt_count", pkt_count, m_cnt);
    chk("framing_err", framing_err, m_err);
  endtask
  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1; din_valid = 1'b1; din = '0; m_axis_tready = 1'b0;
    repeat (cycles) @(negedge clk);
    #1;
    chk("rst_ready", din_ready, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tstrb", m_axis_tstrb, 0);
    chk("rst_tuser", m_axis_tuser, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_count", pkt_count, 0);
    chk("rst_err", framing_err, 0);
    reset = 1'b0; din_valid = 1'b0;
    fifo.delete(); exp_q.delete();
    m_mode = 0; m_err = 1'b0; m_tu = '0; m_cnt = 0; hold = 0;
  endtask
  initial begin
    do_reset(3);
    trdy_mode = 0; gaps = 0;
    gen_pkt(128'hAF000001, 2, 0, 0);
    drain();
    trdy_mode = 1;
    gen_pkt(128'hAF000001, 2, 0, 0);
    drain();
    trdy_mode = 2;
    gen_pkt({8'hAF, 120'h1}, 2, 0, 0);
    gen_pkt({8'hEA, 120'h2}, 3, 0, 0);
    drain();
    trdy_mode = 0;
    gen_pkt(128'h5A5A, 2, 0, 3);
    drain();
    do_reset(1);
    push({3'b010, 55'd0, 16'd0, 128'hC0FFEE});
    push({3'b000, 55'd0, 16'hFFFF, r128()});
    push({3'b001, 55'd0, 16'hFFFF, r128()});
    push({3'b100, 55'd0, 16'h000F, r128()});
    drain();
    chk("short_strb", last.s, 32'h0000000F);
    chk("short_hi", last.d[255:128], 0);
    chk("short_last", last.l, 1);
    gen_pkt(128'h1234, 2, 0, 0);
    for (int i = 0; i < 20 && fifo.size() > 3; i++) step();
    do_reset(1);
    gen_pkt(128'hBEEF, 2, 0, 0);
    drain();
    trdy_mode = 2; gaps = 1;
    for (int p = 0; p < 40; p++)
      gen_pkt(r128(), $urandom_range(1, 4), $urandom_range(0, 5) == 0,
              $urandom_range(0, 9) == 0 ? $urandom_range(1, 3) : 0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
